cache_controller: RTL



---
 rtl/cache_controller.sv | 95 +++++++++
 1 files changed

// File: rtl/cache_controller.sv
// Control FSM for a direct-mapped, 4-word-block, write-through / no-write-allocate data cache.
// Sequences main-memory refills and write-throughs, stalls the processor, and keeps saturating hit/miss counts.
module cache_controller #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic                 Mem_Rd,
  input  logic                 Mem_Wr,
  input  logic                 Miss,
  input  logic                 MM_Ready,
  output logic                 Stall,
  output logic                 block_wr,
  output logic                 MM_Rd,
  output logic                 MM_Wr,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count
);

  typedef enum logic [1:0] {IDLE, RD_REQ, FILL, WR_REQ} state_t;

  state_t state, state_nxt;
  logic   miss_pending;
  logic   rd_hit, rd_miss;

  // NOTE: every output is given a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_nxt = state;
    Stall     = 1'b0;
    block_wr  = 1'b0;
    MM_Rd     = 1'b0;
    MM_Wr     = 1'b0;
    rd_hit    = 1'b0;
    rd_miss   = 1'b0;
    unique case (state)
      IDLE: begin
        if (Mem_Wr) begin
          Stall     = 1'b1;
          state_nxt = WR_REQ;
        end else if (Mem_Rd) begin
          if (Miss) begin
            Stall     = 1'b1;
            rd_miss   = 1'b1;
            state_nxt = RD_REQ;
          end else begin
            rd_hit = 1'b1;
          end
        end
      end
      RD_REQ: begin
        MM_Rd = 1'b1;
        Stall = 1'b1;
        if (MM_Ready) state_nxt = FILL;
      end
      FILL: begin
        block_wr  = 1'b1;
        Stall     = 1'b1;
        state_nxt = IDLE;
      end
      WR_REQ: begin
        MM_Wr = 1'b1;
        Stall = !MM_Ready;
        if (MM_Ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Reset overrides everything, so nothing is requested or stalled while it is held.
    if (rst) begin
      Stall    = 1'b0;
      block_wr = 1'b0;
      MM_Rd    = 1'b0;
      MM_Wr    = 1'b0;
      rd_hit   = 1'b0;
      rd_miss  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state        <= IDLE;
      miss_pending <= 1'b0;
      hit_count    <= '0;
      miss_count   <= '0;
    end else begin
      state <= state_nxt;
      if (state == FILL) miss_pending <= 1'b1;
      else if (rd_hit)   miss_pending <= 1'b0;
      // The read that completes right after a refill is the tail of a miss, not a hit.
      if (rd_hit && !miss_pending && hit_count != '1) hit_count <= hit_count + 1'b1;
      if (rd_miss && miss_count != '1) miss_count <= miss_count + 1'b1;
    end
  end

endmodule
